// File: rtl/quad_step_decoder_if.sv
// Encoder-side bus of the quadrature step decoder: raw A/B lines and error clear in,
// step/direction/error status out.
interface quad_step_decoder_if #(
    parameter int ERR_W = 8
);
    logic             qa;
    logic             qb;
    logic             clr_err;
    logic             step;
    logic             up;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic             ready;

    modport slave  (input  qa, qb, clr_err,
                    output step, up, err, err_count, ready);
    modport master (output qa, qb, clr_err,
                    input  step, up, err, err_count, ready);
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature A/B decoder: per-channel synchroniser + glitch filter, then an
// INIT/RUN FSM that turns legal Gray-code transitions into step/up pulses.
module quad_step_decoder_chan #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_f,
    output logic o_f_nxt
);
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_f;
    logic [3:0]             r_cnt;
    logic                   w_s;
    logic                   w_f_nxt;
    logic [3:0]             w_cnt_nxt;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A level is accepted only after it has differed from r_f for FILTER_LEN cycles.
    always_comb begin
        w_f_nxt   = r_f;
        w_cnt_nxt = '0;
        if (w_s != r_f) begin
            if (r_cnt == 4'(FILTER_LEN - 1))
                w_f_nxt = w_s;
            else
                w_cnt_nxt = r_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
            r_f    <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_f    <= w_f_nxt;
            r_cnt  <= w_cnt_nxt;
        end
    end

    assign o_f     = r_f;
    assign o_f_nxt = w_f_nxt;
endmodule

module quad_step_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3,
    parameter int ERR_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    quad_step_decoder_if.slave  io_q
);
    localparam int INIT_CYC = SYNC_STAGES + FILTER_LEN;

    typedef enum logic {S_INIT, S_RUN} state_t;

    logic [1:0]       w_in;
    logic [1:0]       w_f;
    logic [1:0]       w_f_nxt;
    logic [1:0]       w_chg;
    logic             w_legal;
    logic             w_both;
    logic             w_dir;
    logic             w_err_nxt;

    state_t           r_state;
    logic [4:0]       r_init_cnt;
    logic [1:0]       r_prev;
    logic             r_step;
    logic             r_up;
    logic             r_err;
    logic             r_ready;
    logic [ERR_W-1:0] r_err_cnt;

    // Bit 1 = channel A, bit 0 = channel B.
    assign w_in = {io_q.qa, io_q.qb};

    quad_step_decoder_chan #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_chan [1:0] (
        .clk     (clk),
        .rst     (rst),
        .i_d     (w_in),
        .o_f     (w_f),
        .o_f_nxt (w_f_nxt)
    );

    assign w_chg     = w_f ^ r_prev;
    assign w_legal   = ^w_chg;
    assign w_both    = &w_chg;
    // Up order 00->10->11->01->00 reduces to new A differing from old B.
    assign w_dir     = w_f[1] ^ r_prev[0];
    assign w_err_nxt = (r_state == S_RUN) && w_both;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_INIT;
            r_init_cnt <= '0;
            r_prev     <= '0;
            r_step     <= 1'b0;
            r_up       <= 1'b0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    // Track the filter's next value so RUN starts with prev == cur.
                    r_prev <= w_f_nxt;
                    r_step <= 1'b0;
                    r_err  <= 1'b0;
                    if (r_init_cnt == 5'(INIT_CYC - 1)) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                    end else begin
                        r_init_cnt <= r_init_cnt + 5'd1;
                    end
                end
                S_RUN: begin
                    r_prev <= w_f;
                    r_step <= w_legal;
                    r_err  <= w_both;
                    if (w_legal)
                        r_up <= w_dir;
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err_cnt <= '0;
        else if (io_q.clr_err)
            r_err_cnt <= '0;
        else if (w_err_nxt && (r_err_cnt != {ERR_W{1'b1}}))
            r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign io_q.step      = r_step;
    assign io_q.up        = r_up;
    assign io_q.err       = r_err;
    assign io_q.err_count = r_err_cnt;
    assign io_q.ready     = r_ready;
endmodule
